// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between requesters, the round-robin arbiter and the shared UART transmitter.
// The arbiter takes the slave modport; client/transmitter-side logic takes master.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 24
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    ack;
   logic                  ack_err;
   logic                  uart_tx_req;
   logic [DW-1:0]         uart_tx_data;
   logic                  uart_txs_done;
   logic                  busy;
   logic [GW-1:0]         grant_id;

   modport slave (
      input  req, req_data, uart_txs_done,
      output ack, ack_err, uart_tx_req, uart_tx_data, busy, grant_id
   );

   modport master (
      output req, req_data, uart_txs_done,
      input  ack, ack_err, uart_tx_req, uart_tx_data, busy, grant_id
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one multi-byte UART transmitter between NUM_REQ requesters,
// with a done watchdog and an optional idle gap after each frame.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DW          = 24,
   parameter int TIMEOUT_CYC = 20000,
   parameter int GAP_CYC     = 16
) (
   input  logic             sys_clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
   localparam int GAP_W = $clog2(GAP_CYC) + 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

   state_t               state_reg, state_next;
   logic [GW-1:0]        last_reg, last_next;
   logic [GW-1:0]        grant_reg, grant_next;
   logic [DW-1:0]        data_reg, data_next;
   logic                 tx_req_reg, tx_req_next;
   logic [NUM_REQ-1:0]   ack_reg, ack_next;
   logic                 ack_err_reg, ack_err_next;
   logic                 busy_reg, busy_next;
   logic [WD_W-1:0]      wd_reg, wd_next;
   logic [GAP_W-1:0]     gap_reg, gap_next;

   logic [DW-1:0]        lane [NUM_REQ];
   logic                 sel_valid;
   logic [GW-1:0]        sel_idx;
   logic                 done_hit;
   logic                 timeout_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign lane[gi] = bus.req_data[gi*DW +: DW];
      end
   endgenerate

   // Walk from the offset farthest from last down to last+1 so the nearest requester wins.
   always_comb begin
      int idx;
      idx       = 0;
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         idx = int'(last_reg) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (bus.req[GW'(idx)]) begin
            sel_valid = 1'b1;
            sel_idx   = GW'(idx);
         end
      end
   end

   // Done beats a simultaneous watchdog expiry.
   assign done_hit    = (state_reg == WAIT) && bus.uart_txs_done;
   assign timeout_hit = (state_reg == WAIT) && !bus.uart_txs_done && (wd_reg == WD_LAST);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         last_reg    <= GW'(NUM_REQ - 1);
         grant_reg   <= '0;
         data_reg    <= '0;
         tx_req_reg  <= 1'b0;
         ack_reg     <= '0;
         ack_err_reg <= 1'b0;
         busy_reg    <= 1'b0;
         wd_reg      <= '0;
         gap_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         last_reg    <= last_next;
         grant_reg   <= grant_next;
         data_reg    <= data_next;
         tx_req_reg  <= tx_req_next;
         ack_reg     <= ack_next;
         ack_err_reg <= ack_err_next;
         busy_reg    <= busy_next;
         wd_reg      <= wd_next;
         gap_reg     <= gap_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (sel_valid) state_next = ISSUE;
         ISSUE: state_next = WAIT;
         WAIT:  if (done_hit || timeout_hit) state_next = (GAP_CYC == 0) ? IDLE : GAP;
         GAP:   if (gap_reg == GAP_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      last_next    = last_reg;
      grant_next   = grant_reg;
      data_next    = data_reg;
      tx_req_next  = 1'b0;
      ack_next     = '0;
      ack_err_next = 1'b0;
      busy_next    = (state_next != IDLE);
      wd_next      = wd_reg;
      gap_next     = gap_reg;
      case (state_reg)
         IDLE: begin
            if (sel_valid) begin
               last_next   = sel_idx;
               grant_next  = sel_idx;
               data_next   = lane[sel_idx];
               tx_req_next = 1'b1;
            end
         end
         ISSUE: wd_next = '0;
         WAIT: begin
            if (done_hit || timeout_hit) begin
               ack_next[grant_reg] = 1'b1;
               ack_err_next        = timeout_hit;
               gap_next            = '0;
            end else begin
               wd_next = wd_reg + WD_W'(1);
            end
         end
         GAP: if (gap_reg != GAP_LAST) gap_next = gap_reg + GAP_W'(1);
         default: ;
      endcase
   end

   assign bus.ack          = ack_reg;
   assign bus.ack_err      = ack_err_reg;
   assign bus.uart_tx_req  = tx_req_reg;
   assign bus.uart_tx_data = data_reg;
   assign bus.busy         = busy_reg;
   assign bus.grant_id     = grant_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a main instance (long watchdog, 16-cycle gap) and a
// short-watchdog instance without gap for the timeout path.
module tb_uart_tx_arbiter;
   localparam int NR  = 4;
   localparam int DW  = 24;
   localparam int GAP = 16;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus ();
   uart_tx_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus_to ();

   uart_tx_arbiter #(.NUM_REQ(NR), .DW(DW), .TIMEOUT_CYC(20000), .GAP_CYC(GAP)) u_dut (
      .sys_clk (clk),
      .rst     (rst),
      .bus     (bus.slave)
   );

   uart_tx_arbiter #(.NUM_REQ(NR), .DW(DW), .TIMEOUT_CYC(50), .GAP_CYC(0)) u_dut_to (
      .sys_clk (clk),
      .rst     (rst),
      .bus     (bus_to.slave)
   );

   typedef struct {
      logic [3:0]  req;
      logic [95:0] data;
      int          delay;
      logic [1:0]  grant;
      logic [23:0] exp_data;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_tx(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus.uart_tx_req) begin
            ok = 1'b1;
            return;
         end
      end
      check("tx_req_timeout", 96'd0, 96'd1);
   endtask

   task automatic pulse_done();
      bus.uart_txs_done = 1'b1;
      @(negedge clk);
      bus.uart_txs_done = 1'b0;
   endtask

   task automatic do_frame(input int n, input vec_t v);
      bit ok;
      bus.req      = v.req;
      bus.req_data = v.data;
      wait_tx(40, ok);
      if (!ok) return;
      check("grant_id", 96'(bus.grant_id), 96'(v.grant));
      check("tx_data", 96'(bus.uart_tx_data), 96'(v.exp_data));
      check("busy_at_grant", 96'(bus.busy), 96'd1);
      @(negedge clk);
      check("tx_req_one_cycle", 96'(bus.uart_tx_req), 96'd0);
      repeat (v.delay) @(negedge clk);
      pulse_done();
      check("ack_onehot", 96'(bus.ack), 96'(4'b0001 << v.grant));
      check("ack_err_clear", 96'(bus.ack_err), 96'd0);
      bus.req = '0;
      @(negedge clk);
      check("ack_one_cycle", 96'(bus.ack), 96'd0);
      $display("txn %0d: req=%b grant=%0d data=%h", n, v.req, bus.grant_id, bus.uart_tx_data);
   endtask

   initial begin
      bit ok;
      int t_ack;
      int t0;
      vec_t v;

      vecs[0] = '{4'b0001, {24'h0F0F0F, 24'h0E0E0E, 24'h0D0D0D, 24'hA1B2C3}, 100, 2'd0, 24'hA1B2C3};
      vecs[1] = '{4'b0110, {24'h131313, 24'h121212, 24'h111111, 24'h101010}, 5, 2'd1, 24'h111111};
      vecs[2] = '{4'b0101, {24'h232323, 24'h222222, 24'h212121, 24'h202020}, 1, 2'd2, 24'h222222};
      vecs[3] = '{4'b1001, {24'h333333, 24'h323232, 24'h313131, 24'h303030}, 0, 2'd3, 24'h333333};
      vecs[4] = '{4'b1010, {24'h434343, 24'h424242, 24'h414141, 24'h404040}, 7, 2'd1, 24'h414141};
      vecs[5] = '{4'b0001, {24'h535353, 24'h525252, 24'h515151, 24'h505050}, 2, 2'd0, 24'h505050};
      vecs[6] = '{4'b1000, {24'h636363, 24'h626262, 24'h616161, 24'h606060}, 3, 2'd3, 24'h636363};
      vecs[7] = '{4'b0011, {24'h737373, 24'h727272, 24'h717171, 24'h707070}, 4, 2'd0, 24'h707070};

      rst = 1'b1;
      bus.req = '0;    bus.req_data = '0;    bus.uart_txs_done = 1'b0;
      bus_to.req = '0; bus_to.req_data = '0; bus_to.uart_txs_done = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 96'(bus.busy), 96'd0);
      check("rst_ack", 96'(bus.ack), 96'd0);
      check("rst_tx_req", 96'(bus.uart_tx_req), 96'd0);
      check("rst_tx_data", 96'(bus.uart_tx_data), 96'd0);
      check("rst_grant", 96'(bus.grant_id), 96'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) do_frame(i, vecs[i]);

      // Spurious done in GAP, then the gap length seen through busy.
      pulse_done();
      check("gap_done_ignored", 96'(bus.ack), 96'd0);
      repeat (GAP - 3) @(negedge clk);
      check("gap_busy_last", 96'(bus.busy), 96'd1);
      @(negedge clk);
      check("gap_to_idle", 96'(bus.busy), 96'd0);
      pulse_done();
      check("idle_done_ack", 96'(bus.ack), 96'd0);
      check("idle_done_busy", 96'(bus.busy), 96'd0);

      bus.req = 4'b0100;
      bus.req_data = {24'h888888, 24'h777777, 24'h666666, 24'h555555};
      wait_tx(10, ok);
      check("spur_grant", 96'(bus.grant_id), 96'd2);
      pulse_done();
      check("issue_done_ack", 96'(bus.ack), 96'd0);
      check("issue_done_busy", 96'(bus.busy), 96'd1);
      repeat (5) @(negedge clk);
      check("wait_no_ack", 96'(bus.ack), 96'd0);
      pulse_done();
      check("spur_real_ack", 96'(bus.ack), 96'(4'b0100));
      $display("txn spurious: grant=%0d data=%h", bus.grant_id, bus.uart_tx_data);

      // Data and req changes after grant must not disturb the frame.
      bus.req = 4'b0001;
      bus.req_data = {24'h111111, 24'h222222, 24'h333333, 24'hC0FFEE};
      wait_tx(40, ok);
      check("stab_grant", 96'(bus.grant_id), 96'd0);
      @(negedge clk);
      bus.req = '0;
      bus.req_data = {4{24'hBADBAD}};
      repeat (4) @(negedge clk);
      check("stab_data", 96'(bus.uart_tx_data), 96'h0C0FFEE);
      pulse_done();
      check("stab_ack", 96'(bus.ack), 96'(4'b0001));
      $display("txn stability: grant=%0d data=%h", bus.grant_id, bus.uart_tx_data);

      // Reset 10 cycles into WAIT.
      bus.req = 4'b0010;
      wait_tx(40, ok);
      check("rw_grant", 96'(bus.grant_id), 96'd1);
      @(negedge clk);
      repeat (10) @(negedge clk);
      check("rw_busy_pre", 96'(bus.busy), 96'd1);
      #1 rst = 1'b1;
      #1;
      check("rw_async_busy", 96'(bus.busy), 96'd0);
      check("rw_async_grant", 96'(bus.grant_id), 96'd0);
      check("rw_async_data", 96'(bus.uart_tx_data), 96'd0);
      check("rw_async_ack", 96'(bus.ack), 96'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("txn reset_mid_wait: outputs cleared");

      // Fairness with all requests held.
      bus.req = 4'b1111;
      bus.req_data = {24'hDD0003, 24'hDD0002, 24'hDD0001, 24'hDD0000};
      t_ack = 0;
      for (int k = 0; k < 6; k++) begin
         wait_tx(40, ok);
         if (!ok) break;
         check("fair_grant", 96'(bus.grant_id), 96'(k % 4));
         check("fair_data", 96'(bus.uart_tx_data), 96'(24'hDD0000 + (k % 4)));
         check("fair_no_ack", 96'(bus.ack), 96'd0);
         if (k > 0) check("fair_gap", 96'(cyc - t_ack), 96'(GAP + 1));
         repeat (3) @(negedge clk);
         pulse_done();
         check("fair_ack", 96'(bus.ack), 96'(4'b0001 << (k % 4)));
         t_ack = cyc;
         $display("txn fair %0d: grant=%0d data=%h", k, bus.grant_id, bus.uart_tx_data);
      end
      bus.req = '0;

      // Watchdog abort on the short-timeout instance, followed by a normal frame with no gap.
      bus_to.req = 4'b0100;
      bus_to.req_data = {24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D};
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = bus_to.uart_tx_req;
      end
      check("to_tx_seen", 96'(ok), 96'd1);
      check("to_grant", 96'(bus_to.grant_id), 96'd2);
      t0 = cyc;
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         @(negedge clk);
         ok = (bus_to.ack != '0);
      end
      check("to_latency", 96'(cyc - t0), 96'd51);
      check("to_ack", 96'(bus_to.ack), 96'(4'b0100));
      check("to_ack_err", 96'(bus_to.ack_err), 96'd1);
      $display("txn timeout: grant=%0d ack_err=%0d", bus_to.grant_id, bus_to.ack_err);
      bus_to.req = 4'b0001;
      @(negedge clk);
      check("to_ack_one_cycle", 96'(bus_to.ack), 96'd0);
      check("to_err_one_cycle", 96'(bus_to.ack_err), 96'd0);
      check("to_next_tx", 96'(bus_to.uart_tx_req), 96'd1);
      check("to_next_grant", 96'(bus_to.grant_id), 96'd0);
      @(negedge clk);
      bus_to.uart_txs_done = 1'b1;
      @(negedge clk);
      bus_to.uart_txs_done = 1'b0;
      check("to_next_ack", 96'(bus_to.ack), 96'(4'b0001));
      check("to_next_err", 96'(bus_to.ack_err), 96'd0);
      bus_to.req = '0;
      $display("txn after_timeout: grant=%0d data=%h", bus_to.grant_id, bus_to.uart_tx_data);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
